lsu_seq: RTL and testbench

Load/store sequencer between the core's memory-stage control and a single-port word-addressed data memory with a req/ack handshake. It accepts one load or store per `start` pulse and decodes width and signedness from the instruction word. It checks alignment, drives byte enables and replicated store data, waits for the memory acknowledge with a timeout, then returns the extended load result or a fault code. It is the only master on the data-memory port.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_ld_extend.sv | 43 ++++
 rtl/lsu_seq.sv | 176 +++++++++++++++++
 tb/tb_lsu_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store sequencer.
// Holds the opcode and funct3 codes the sequencer decodes, the fault codes
// reported on completion, the FSM state encoding and a decode helper that
// classifies a request before any memory traffic is issued.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Classifies a request at accept time. Illegal encodings take priority
  // over misalignment; anything returning FLT_OK goes out to memory.
  function automatic logic [1:0] decode_fault(input logic [6:0] opcode,
                                              input logic [2:0] funct3,
                                              input logic [1:0] off);
    logic legal;
    logic isHalf;
    logic isWord;
    legal  = 1'b0;
    isHalf = (funct3 == F3_H) || (funct3 == F3_HU);
    isWord = (funct3 == F3_W);
    if (opcode == OP_LOAD) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end else if (opcode == OP_STORE) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end
    if (!legal) begin
      decode_fault = FLT_ILLEGAL;
    end else if ((isHalf && off[0]) || (isWord && (off != 2'b00))) begin
      decode_fault = FLT_MISALIGN;
    end else begin
      decode_fault = FLT_OK;
    end
  endfunction

endpackage

// File: rtl/lsu_ld_extend.sv
// lsu_ld_extend: selects the addressed byte/halfword out of a memory word
// and sign- or zero-extends it according to the load funct3.
// Ports:
//   word_i    read word from memory
//   funct3_i  load width/signedness
//   off_i     byte offset within the word
//   result_o  extended 32-bit load result
module lsu_ld_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] result_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection: byte by full offset, halfword by offset bit 1 only,
  // since halfword loads reaching here are already known to be aligned.
  always_comb begin
    case (off_i)
      2'd0:    byteSel = word_i[7:0];
      2'd1:    byteSel = word_i[15:8];
      2'd2:    byteSel = word_i[23:16];
      default: byteSel = word_i[31:24];
    endcase
    halfSel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extension by funct3; unused encodings fall back to the raw word.
  always_comb begin
    case (funct3_i)
      F3_B:    result_o = {{24{byteSel[7]}}, byteSel};
      F3_BU:   result_o = {24'h0, byteSel};
      F3_H:    result_o = {{16{halfSel[15]}}, halfSel};
      F3_HU:   result_o = {16'h0, halfSel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer between the memory-stage control and a
// single-port word-addressed data memory with req/ack handshake.
// Ports:
//   clock, reset_n            clock and async active-low reset
//   start, ir, addr, wdata    request: instruction word, byte address, store data
//   busy, done, fault, rdata  status: in-flight, completion pulse, fault code, load result
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata   registered memory request
//   mem_ack, mem_rdata        memory acknowledge and read word
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  decFault;
  logic        isStore;
  logic [3:0]  stBe;
  logic [31:0] stWdata;
  logic [31:0] ldResult;
  logic        unusedIrBits;

  logic [1:0]  fault_q;
  logic [31:0] rdata_q;
  logic        memReq_q;
  logic        memWe_q;
  logic [31:0] memAddr_q;
  logic [3:0]  memBe_q;
  logic [31:0] memWdata_q;
  logic [7:0]  ackCnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        store_q;

  assign unusedIrBits = ^{ir[31:15], ir[11:7]};

  assign decFault = decode_fault(ir[6:0], ir[14:12], addr[1:0]);
  assign isStore  = (ir[6:0] == OP_STORE);

  // Store lane encoding: byte enables shifted to the addressed lane and the
  // source data replicated so every lane carries it.
  always_comb begin
    stBe    = 4'hF;
    stWdata = wdata;
    case (ir[14:12])
      F3_B: begin
        stBe    = 4'b0001 << addr[1:0];
        stWdata = {4{wdata[7:0]}};
      end
      F3_H: begin
        stBe    = 4'b0011 << addr[1:0];
        stWdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_ld_extend u_ld_extend (
    .word_i   (mem_rdata),
    .funct3_i (funct3_q),
    .off_i    (off_q),
    .result_o (ldResult)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and status outputs. Faults caught at decode skip ACCESS
  // entirely so they never raise mem_req.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (decFault == FLT_OK) ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || (ackCnt_q == TO_LAST)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch the request on accept, hold the memory outputs stable
  // through ACCESS, and capture the result. The ack test comes first so an
  // ack on the final permitted cycle wins over the timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fault_q    <= FLT_OK;
      rdata_q    <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memBe_q    <= '0;
      memWdata_q <= '0;
      ackCnt_q   <= '0;
      funct3_q   <= '0;
      off_q      <= '0;
      store_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            fault_q  <= decFault;
            rdata_q  <= '0;
            ackCnt_q <= '0;
            funct3_q <= ir[14:12];
            off_q    <= addr[1:0];
            store_q  <= isStore;
            if (decFault == FLT_OK) begin
              memReq_q   <= 1'b1;
              memWe_q    <= isStore;
              memAddr_q  <= {addr[31:2], 2'b00};
              memBe_q    <= isStore ? stBe : 4'hF;
              memWdata_q <= stWdata;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            memReq_q <= 1'b0;
            fault_q  <= FLT_OK;
            rdata_q  <= store_q ? 32'h0 : ldResult;
          end else if (ackCnt_q == TO_LAST) begin
            memReq_q <= 1'b0;
            fault_q  <= FLT_TIMEOUT;
          end else begin
            ackCnt_q <= ackCnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_be    = memBe_q;
  assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: self-checking bench for lsu_seq with directed cases and
// randomized requests compared against an arithmetic reference model.
module tb_lsu_seq;

  localparam int TIMEOUT = 4;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] ir;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [1:0]  fault;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int numChecks = 0;
  int numFails  = 0;

  lsu_seq #(.ACK_TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .ir        (ir),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mkIr(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'h0, op};
  endfunction

  // Reference model: derives the outcome from the instruction's meaning
  // (access size in bytes, offset arithmetic, two's-complement extension).
  task automatic model(input logic [31:0] irv, input logic [31:0] addrv,
                       input logic [31:0] wdv, input logic [31:0] word,
                       input int ackDelay,
                       output logic [1:0] eflt, output logic [31:0] erd,
                       output logic [3:0] ebe, output logic [31:0] ewd,
                       output bit estore);
    int op, f3, size, off;
    bit legal;
    longint v, span;
    op     = int'(irv[6:0]);
    f3     = int'(irv[14:12]);
    off    = int'(addrv % 4);
    estore = (op == 'h23);
    legal  = (op == 'h03 && (f3 <= 2 || f3 == 4 || f3 == 5)) || (op == 'h23 && f3 <= 2);
    size   = 1 << (f3 % 4);
    if (!legal) eflt = 2'd3;
    else if (off % size != 0) eflt = 2'd1;
    else if (ackDelay < 0 || ackDelay >= TIMEOUT) eflt = 2'd2;
    else eflt = 2'd0;
    ebe = estore ? 4'(((1 << size) - 1) << off) : 4'hF;
    if (size == 1) ewd = 32'(wdv[7:0]) * 32'h01010101;
    else if (size == 2) ewd = 32'(wdv[15:0]) * 32'h00010001;
    else ewd = wdv;
    if (eflt != 2'd0 || estore) begin
      erd = 32'h0;
    end else if (size == 4) begin
      erd = word;
    end else begin
      span = longint'(1) << (8 * size);
      v = (longint'(word) >> (8 * off)) % span;
      if (f3 < 4 && v >= span / 2) v = v - span;
      erd = 32'(v);
    end
  endtask

  // Runs one request end to end. ackDelay is the index of the request cycle
  // in which the memory acknowledges (-1: never). With noisy set, stray
  // start pulses and acks outside the request window are injected.
  task automatic applyStimulus(input string name, input logic [31:0] irv,
                               input logic [31:0] addrv, input logic [31:0] wdv,
                               input logic [31:0] word, input int ackDelay,
                               input bit noisy);
    logic [1:0]  eflt;
    logic [31:0] erd, ewd;
    logic [3:0]  ebe;
    bit          estore;
    int reqCycles, busyCycles, doneCycle, expReq, expDone;
    model(irv, addrv, wdv, word, ackDelay, eflt, erd, ebe, ewd, estore);
    if (eflt == 2'd1 || eflt == 2'd3) begin
      expReq = 0; expDone = 1;
    end else if (eflt == 2'd2) begin
      expReq = TIMEOUT; expDone = TIMEOUT + 1;
    end else begin
      expReq = ackDelay + 1; expDone = ackDelay + 2;
    end
    @(negedge clock);
    start = 1'b1; ir = irv; addr = addrv; wdata = wdv;
    @(posedge clock); #1;
    start = 1'b0; ir = $urandom; addr = $urandom; wdata = $urandom;
    reqCycles = 0; busyCycles = 0; doneCycle = 0;
    for (int i = 1; i <= 40 && doneCycle == 0; i++) begin
      if (busy) busyCycles++;
      mem_rdata = $urandom;
      if (mem_req) begin
        checkOutput({name, ".memAddr"}, mem_addr, addrv & 32'hFFFF_FFFC);
        checkOutput({name, ".memBe"}, 32'(mem_be), 32'(ebe));
        checkOutput({name, ".memWe"}, 32'(mem_we), 32'(estore));
        if (estore) checkOutput({name, ".memWdata"}, mem_wdata, ewd);
        mem_ack = (reqCycles == ackDelay);
        if (mem_ack) mem_rdata = word;
        reqCycles++;
        start = noisy & 1'($urandom_range(0, 1));
      end else begin
        start   = 1'b0;
        mem_ack = noisy & 1'($urandom_range(0, 1));
      end
      if (done) begin
        doneCycle = i;
        checkOutput({name, ".fault"}, 32'(fault), 32'(eflt));
        checkOutput({name, ".rdata"}, rdata, erd);
        checkOutput({name, ".reqInDone"}, 32'(mem_req), 32'd0);
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    checkOutput({name, ".doneCycle"}, 32'(doneCycle), 32'(expDone));
    checkOutput({name, ".reqCycles"}, 32'(reqCycles), 32'(expReq));
    checkOutput({name, ".busyCycles"}, 32'(busyCycles), 32'(expDone));
    checkOutput({name, ".doneAfter"}, 32'(done), 32'd0);
    checkOutput({name, ".busyAfter"}, 32'(busy), 32'd0);
    checkOutput({name, ".faultHeld"}, 32'(fault), 32'(eflt));
    checkOutput({name, ".rdataHeld"}, rdata, erd);
    mem_ack = 1'b0;
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, ".busy"}, 32'(busy), 32'd0);
    checkOutput({name, ".done"}, 32'(done), 32'd0);
    checkOutput({name, ".fault"}, 32'(fault), 32'd0);
    checkOutput({name, ".rdata"}, rdata, 32'd0);
    checkOutput({name, ".memReq"}, 32'(mem_req), 32'd0);
    checkOutput({name, ".memWe"}, 32'(mem_we), 32'd0);
    checkOutput({name, ".memAddr"}, mem_addr, 32'd0);
    checkOutput({name, ".memBe"}, 32'(mem_be), 32'd0);
    checkOutput({name, ".memWdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int sel, dly;
    reset_n = 1'b0; start = 1'b0; ir = '0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #2;
    checkResetValues("reset");
    #10;
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus("lbNeg",    mkIr(7'h03, 3'b000), 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0);
    applyStimulus("lhuHigh",  mkIr(7'h03, 3'b101), 32'h202, 32'h0, 32'hBEEF_0001, 3, 1'b0);
    applyStimulus("sbLane1",  mkIr(7'h23, 3'b000), 32'h301, 32'h1234_56A5, 32'h0, 0, 1'b0);
    applyStimulus("lwMisal",  mkIr(7'h03, 3'b010), 32'h402, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus("shMisal",  mkIr(7'h23, 3'b001), 32'h011, 32'hFFFF, 32'h0, 0, 1'b0);
    applyStimulus("lwTmo",    mkIr(7'h03, 3'b010), 32'h600, 32'h0, 32'h1111_2222, -1, 1'b0);
    applyStimulus("lwLastAck", mkIr(7'h03, 3'b010), 32'h604, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
    applyStimulus("illegalOp", mkIr(7'h33, 3'b000), 32'h700, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus("lhNoisy",  mkIr(7'h03, 3'b001), 32'h802, 32'h0, 32'h9876_0000, 2, 1'b1);
    applyStimulus("lbPrime",  mkIr(7'h03, 3'b000), 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0);

    // Asynchronous reset while a store is waiting for its ack.
    @(negedge clock);
    start = 1'b1; ir = mkIr(7'h23, 3'b010); addr = 32'h900; wdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    checkOutput("midReset.reqBefore", 32'(mem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("midReset");
    mem_ack = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("postReset.memReq", 32'(mem_req), 32'd0);
    checkOutput("postReset.busy", 32'(busy), 32'd0);
    checkOutput("postReset.done", 32'(done), 32'd0);
    mem_ack = 1'b0;

    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) op = 7'h03;
      else if (sel < 9) op = 7'h23;
      else op = 7'($urandom);
      f3  = 3'($urandom_range(0, 7));
      dly = int'($urandom_range(0, 5));
      applyStimulus("rand", {17'($urandom), f3, 5'($urandom), op}, $urandom, $urandom,
                    $urandom, dly, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
